// File: rtl/register_file_access_ctrl.sv
// register_file_access_ctrl: valid/ready front end driving a DEPTH x WIDTH bank of register cells.
// Optional RFC_ADDR_CHECK_EN reports out-of-range addresses on rsp_err.
module register_file_access_ctrl #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [DEPTH-1:0]  cell_wen,
  output logic [WIDTH-1:0]  cell_din,
  output logic [DEPTH-1:0]  cell_ren,
  input  logic [WIDTH-1:0]  cell_rbus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d, rdata_q, rdata_d;
  logic err_q, err_d, err_chk, in_range;
  logic [DEPTH-1:0] sel;
  // Per-row address match; an out-of-range address simply matches no row.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) sel[i] = addr_q == ADDR_W'(i);
  end
  assign in_range = |sel;
`ifdef RFC_ADDR_CHECK_EN
  assign err_chk = ~in_range;
`else
  assign err_chk = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        din_d   = req_write ? req_wdata : din_q;
        state_d = req_write ? WRITE : READ;
      end
      WRITE: begin
        rdata_d = '0;
        err_d   = err_chk;
        state_d = RESP;
      end
      READ: begin
        rdata_d = in_range ? cell_rbus : '0;
        err_d   = err_chk;
        state_d = RESP;
      end
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign cell_wen  = state_q == WRITE ? sel : '0;
  assign cell_ren  = state_q == READ ? sel : '0;
  assign cell_din  = din_q;
endmodule
